// File: rtl/dtree_seq_walker_pkg.sv
// Shared types and widths for the sequential decision-tree walker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dtree_pkg;

  localparam int N_FEAT    = 16;
  localparam int FEAT_W    = 8;
  localparam int CLASS_W   = 4;
  localparam int N_NODES   = 64;
  localparam int MAX_DEPTH = 15;

  // Index widths never drop below one bit so degenerate sizes still elaborate.
  function automatic int fidx_w(input int n_feat);
    return (n_feat > 1) ? $clog2(n_feat) : 1;
  endfunction

  function automatic int addr_w(input int n_nodes);
    return (n_nodes > 1) ? $clog2(n_nodes) : 1;
  endfunction

  function automatic int node_w(input int n_feat, input int feat_w, input int n_nodes);
    return 1 + fidx_w(n_feat) + feat_w + 2 * addr_w(n_nodes);
  endfunction

  localparam int FIDX_W  = fidx_w(N_FEAT);
  localparam int AW      = addr_w(N_NODES);
  localparam int NODE_W  = node_w(N_FEAT, FEAT_W, N_NODES);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  // Field order MSB first; a leaf carries its class in the low CLASS_W bits.
  typedef struct packed {
    logic              leaf;
    logic [FIDX_W-1:0] fidx;
    logic [FEAT_W-1:0] thresh;
    logic [AW-1:0]     left;
    logic [AW-1:0]     right;
  } node_t;

  // Leaf, class 0: an unloaded table classifies everything as class 0.
  localparam node_t NODE_RST = node_t'({1'b1, {(NODE_W-1){1'b0}}});

endpackage

// File: rtl/dtree_seq_walker_if.sv
// Config, sample and result handshake bundle for the tree walker.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on samples and results; config gated by cfg_ready.
interface dtree_seq_walker_if;
  import dtree_pkg::*;

  logic                     cfg_we;
  logic [AW-1:0]            cfg_addr;
  logic [NODE_W-1:0]        cfg_wdata;
  logic                     cfg_ready;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feats;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic [DEPTH_W-1:0]       out_depth;
  logic                     out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feats, out_ready,
    input  cfg_ready, in_ready, out_valid, out_class, out_depth, out_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feats, out_ready,
    output cfg_ready, in_ready, out_valid, out_class, out_depth, out_err
  );

endinterface

// File: rtl/dtree_seq_walker_node_table.sv
// Node table: register file, one synchronous write port, one asynchronous read port.
// Latency: write visible after the write edge; read is combinational.
// Backpressure: none; the caller decides when writes are allowed.
module dtree_node_table
  import dtree_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  node_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output node_t         o_rdata
);

  node_t r_mem [N_NODES];

  // Every entry returns to the leaf-class-0 node on reset; otherwise single-port write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) begin
        r_mem[i] <= NODE_RST;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree walker: one node per cycle through a shared feature mux and <= comparator.
// Latency: result valid D+1 cycles after accept for a path of D internal nodes.
// Backpressure: result held until out_ready; no new sample or table write until back in IDLE.
// Optional macro DTREE_PERF_CNT_EN adds saturating perf_infer / perf_cycles counters.
module dtree_seq_walker
  import dtree_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef DTREE_PERF_CNT_EN
  output logic [15:0] perf_infer,
  output logic [15:0] perf_cycles,
`endif
  dtree_seq_walker_if.slave bus
);

  state_e                          r_state;
  logic [AW-1:0]                   r_ptr;
  logic [DEPTH_W-1:0]              r_depth;
  logic [N_FEAT-1:0][FEAT_W-1:0]   r_feats;
  logic                            r_idle;
  logic                            r_cfg_ready;
  logic                            r_out_valid;
  logic                            r_out_err;
  logic [CLASS_W-1:0]              r_out_class;
  logic [DEPTH_W-1:0]              r_out_depth;

  node_t                           w_node;
  logic                            w_tbl_we;
  logic [FEAT_W-1:0]               w_feat;
  logic                            w_go_left;
  logic [AW-1:0]                   w_child;
  logic                            w_walk_err;

  // Writes land only while idle, so a walk never sees the table change under it.
  assign w_tbl_we = bus.cfg_we & (r_state == IDLE);

  dtree_node_table u_table (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_tbl_we),
    .i_waddr (bus.cfg_addr),
    .i_wdata (node_t'(bus.cfg_wdata)),
    .i_raddr (r_ptr),
    .o_rdata (w_node)
  );

  // Shared feature mux; an out-of-range feature index reads as zero.
  always_comb begin
    w_feat = '0;
    if (32'(w_node.fidx) < N_FEAT) begin
      w_feat = r_feats[w_node.fidx];
    end
  end

  assign w_go_left  = (w_feat <= w_node.thresh);
  assign w_child    = w_go_left ? w_node.left : w_node.right;
  assign w_walk_err = (32'(r_depth) == MAX_DEPTH) || (32'(w_child) >= N_NODES);

  // Walker FSM: capture sample, follow one node per cycle, hold result until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_depth     <= '0;
      r_feats     <= '0;
      r_idle      <= 1'b1;
      r_cfg_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_class <= '0;
      r_out_depth <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Config has priority: a write cycle never accepts a sample.
          if (!bus.cfg_we && bus.in_valid) begin
            r_feats     <= bus.in_feats;
            r_ptr       <= '0;
            r_depth     <= '0;
            r_idle      <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_state     <= WALK;
          end
        end
        WALK: begin
          if (w_node.leaf) begin
            r_out_class <= w_node[CLASS_W-1:0];
            r_out_depth <= r_depth;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (w_walk_err) begin
            r_out_class <= '0;
            r_out_depth <= r_depth;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_ptr   <= w_child;
            r_depth <= r_depth + DEPTH_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_class <= '0;
            r_out_depth <= '0;
            r_idle      <= 1'b1;
            r_cfg_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_idle      <= 1'b1;
          r_cfg_ready <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.in_ready  = r_idle & ~bus.cfg_we;
  assign bus.out_valid = r_out_valid;
  assign bus.out_class = r_out_class;
  assign bus.out_depth = r_out_depth;
  assign bus.out_err   = r_out_err;

`ifdef DTREE_PERF_CNT_EN
  logic [15:0] r_perf_infer;
  logic [15:0] r_perf_cycles;

  // Saturating counters of completed results and cycles spent walking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_infer  <= '0;
      r_perf_cycles <= '0;
    end else begin
      if ((r_state == WALK) && (r_perf_cycles != 16'hFFFF)) begin
        r_perf_cycles <= r_perf_cycles + 16'd1;
      end
      if ((r_state == DONE) && bus.out_ready && (r_perf_infer != 16'hFFFF)) begin
        r_perf_infer <= r_perf_infer + 16'd1;
      end
    end
  end

  assign perf_infer  = r_perf_infer;
  assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_dtree_seq_walker.sv
// Self-checking bench for dtree_seq_walker: directed vectors, hold/reset corners, random trees vs model.
// Latency: checks result latency against the path length.
// Backpressure: exercises out_ready stall and config lockout outside IDLE.
module tb_dtree_seq_walker;

  localparam int NN = 64;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dtree_seq_walker_if bus();

`ifdef DTREE_PERF_CNT_EN
  logic [15:0] perf_infer;
  logic [15:0] perf_cycles;
`endif

  dtree_seq_walker dut (
    .clk         (clk),
    .rst         (rst),
`ifdef DTREE_PERF_CNT_EN
    .perf_infer  (perf_infer),
    .perf_cycles (perf_cycles),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference copy of the node table, as raw node words.
  logic [24:0] m_word [NN];

  typedef struct {
    logic [7:0] f15;
    int         cls;
    int         dep;
    int         lat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [24:0] mk_int(input int fi, input int th, input int l, input int r);
    return {1'b0, 4'(fi), 8'(th), 6'(l), 6'(r)};
  endfunction

  function automatic logic [24:0] mk_leaf(input int c);
    return {1'b1, 20'd0, 4'(c)};
  endfunction

  function automatic logic [127:0] f15_vec(input logic [7:0] v);
    logic [127:0] f;
    f = '0;
    f[127:120] = v;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NN; i++) m_word[i] = mk_leaf(0);
  endtask

  // Walk the reference table from the root following the decision rule.
  task automatic model_eval(input logic [127:0] f, output int cls, output int dep, output int err);
    int p;
    int fi;
    int fv;
    int nxt;
    logic [24:0] w;
    p = 0; dep = 0; err = 0; cls = 0;
    for (int k = 0; k < 100; k++) begin
      w = m_word[p];
      if (w[24]) begin
        cls = int'(w[3:0]);
        break;
      end
      if (dep == 15) begin
        err = 1;
        break;
      end
      fi  = int'(w[23:20]);
      fv  = int'(f[fi*8 +: 8]);
      nxt = (fv <= int'(w[19:12])) ? int'(w[11:6]) : int'(w[5:0]);
      if (nxt >= NN) begin
        err = 1;
        break;
      end
      p = nxt;
      dep++;
    end
  endtask

  task automatic cfg(input int a, input logic [24:0] w);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 6'(a);
    bus.cfg_wdata = w;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    m_word[a] = w;
  endtask

  task automatic accept(input logic [127:0] f);
    int k;
    k = 0;
    @(negedge clk);
    bus.in_feats = f;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      bus.cfg_we = 1'b0;
    end while (!bus.out_valid && lat < 200);
    if (!bus.out_valid) begin
      chk("result_timeout", 0, 1);
      lat = -1;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    chk("in_ready_in_done", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("out_valid_after_hs", int'(bus.out_valid), 0);
  endtask

  task automatic run(input logic [127:0] f, output int cls, output int dep, output int err, output int lat);
    accept(f);
    wait_valid(lat);
    cls = int'(bus.out_class);
    dep = int'(bus.out_depth);
    err = int'(bus.out_err);
    handshake();
  endtask

  task automatic load_base_tree();
    cfg(0, mk_int(15, 127, 1, 2));
    cfg(1, mk_leaf(5));
    cfg(2, mk_int(15, 191, 3, 4));
    cfg(3, mk_leaf(7));
    cfg(4, mk_leaf(9));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cls, dep, err, lat;
    int ecls, edep, eerr;
    logic [127:0] f;
    logic [24:0] w;

    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{8'd100, 5, 1, 2};
    vecs[1] = '{8'd127, 5, 1, 2};
    vecs[2] = '{8'd128, 7, 2, 3};
    vecs[3] = '{8'd200, 9, 2, 3};
    vecs[4] = '{8'd0,   5, 1, 2};
    vecs[5] = '{8'd191, 7, 2, 3};
    vecs[6] = '{8'd192, 9, 2, 3};
    vecs[7] = '{8'd255, 9, 2, 3};

    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.in_valid = 1'b0; bus.in_feats = '0; bus.out_ready = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_class", int'(bus.out_class), 0);
    chk("rst_out_depth", int'(bus.out_depth), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    rst = 1'b0;

    // Empty table: root is a class-0 leaf
    f = '0;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = 8'd100;
    run(f, cls, dep, err, lat);
    chk("empty_class", cls, 0);
    chk("empty_depth", dep, 0);
    chk("empty_lat", lat, 1);

    // Config cycle blocks a simultaneous sample
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 6'd1; bus.cfg_wdata = mk_leaf(5);
    bus.in_valid = 1'b1; bus.in_feats = f15_vec(8'd0);
    #1 chk("cfg_blocks_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    m_word[1] = mk_leaf(5);
    chk("cfg_no_accept", int'(bus.cfg_ready), 1);

    load_base_tree();

    // Directed vectors on feature 15
    for (int i = 0; i < 8; i++) begin
      run(f15_vec(vecs[i].f15), cls, dep, err, lat);
      chk($sformatf("vec%0d_class", i), cls, vecs[i].cls);
      chk($sformatf("vec%0d_depth", i), dep, vecs[i].dep);
      chk($sformatf("vec%0d_err", i), err, 0);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Hold result under out_ready=0, try to overwrite n4 meanwhile
    accept(f15_vec(8'd200));
    wait_valid(lat);
    chk("hold_lat", lat, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 6'd4; bus.cfg_wdata = mk_leaf(3);
      end else begin
        bus.cfg_we = 1'b0;
      end
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_class", int'(bus.out_class), 9);
      chk("hold_depth", int'(bus.out_depth), 2);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_cfg_ready", int'(bus.cfg_ready), 0);
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
    handshake();
    run(f15_vec(8'd200), cls, dep, err, lat);
    chk("n4_unchanged_class", cls, 9);

    // Self-loop at root: depth limit error
    cfg(0, mk_int(15, 127, 0, 0));
    run(f15_vec(8'd50), cls, dep, err, lat);
    chk("loop_err", err, 1);
    chk("loop_class", cls, 0);
    chk("loop_depth", dep, 15);
    chk("loop_lat", lat, 16);

    // Deep path through the last table entry
    cfg(0, mk_int(15, 127, 1, 2));
    cfg(2, mk_int(15, 191, 3, 63));
    cfg(63, mk_int(0, 0, 3, 4));
    run(f15_vec(8'd255), cls, dep, err, lat);
    chk("n63_class", cls, 7);
    chk("n63_depth", dep, 3);
    chk("n63_err", err, 0);
    chk("n63_lat", lat, 4);
    f = f15_vec(8'd255);
    f[7:0] = 8'd1;
    run(f, cls, dep, err, lat);
    chk("n63_right_class", cls, 9);
    chk("n63_right_depth", dep, 3);

    // Random trees: first acyclic-biased, then unconstrained children
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NN; i++) begin
        if (i == NN - 1 || $urandom_range(0, 9) < 4) begin
          w = {1'b1, 20'($urandom), 4'($urandom)};
        end else if (t == 0) begin
          w = mk_int(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                     int'($urandom_range(i + 1, NN - 1)), int'($urandom_range(i + 1, NN - 1)));
        end else begin
          w = mk_int(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, NN - 1)), int'($urandom_range(0, NN - 1)));
        end
        cfg(i, w);
      end
      for (int s = 0; s < 30; s++) begin
        f = {$urandom, $urandom, $urandom, $urandom};
        model_eval(f, ecls, edep, eerr);
        accept(f);
        if ($urandom_range(0, 1) == 1) begin
          bus.cfg_we = 1'b1;
          bus.cfg_addr = 6'($urandom);
          bus.cfg_wdata = 25'($urandom);
        end
        wait_valid(lat);
        cls = int'(bus.out_class);
        dep = int'(bus.out_depth);
        err = int'(bus.out_err);
        handshake();
        chk($sformatf("rnd%0d_%0d_class", t, s), cls, ecls);
        chk($sformatf("rnd%0d_%0d_depth", t, s), dep, edep);
        chk($sformatf("rnd%0d_%0d_err", t, s), err, eerr);
        chk($sformatf("rnd%0d_%0d_lat", t, s), lat, edep + 1);
      end
    end

    // Reset during the second walk cycle
    for (int i = 0; i < NN; i++) cfg(i, mk_leaf(0));
    load_base_tree();
    accept(f15_vec(8'd200));
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_cfg_ready", int'(bus.cfg_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("postrst_in_ready", int'(bus.in_ready), 1);
    chk("postrst_out_valid", int'(bus.out_valid), 0);
    run(f15_vec(8'd200), cls, dep, err, lat);
    model_eval(f15_vec(8'd200), ecls, edep, eerr);
    chk("postrst_class", cls, ecls);
    chk("postrst_depth", dep, 0);
    chk("postrst_lat", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dtree_seq_walker.md
Name: dtree_seq_walker

Overview:
Sequential decision-tree inference engine for printed-classifier experiments.
- Holds the tree as a small loadable node table and walks it one node per cycle, sharing a single feature mux and a single <= comparator across all nodes.
- Accepts a sample via valid/ready, returns a class label plus path depth via valid/ready.
- Sits between the sample-acquisition front end and the result collector.
- Swapping Pareto tree variants is a table reload instead of a re-synthesis.

Parameters:
N_FEAT, 16, number of input features
FEAT_W, 8, feature and threshold width (unsigned)
CLASS_W, 4, class label width
N_NODES, 64, node table depth
MAX_DEPTH, 15, max internal nodes traversed before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  node table write strobe
cfg_addr  in  $clog2(N_NODES)  node index
cfg_wdata  in  NODE_W  node word
cfg_ready  out  1  table writable (state IDLE)
in_valid  in  1  sample offered
in_ready  out  1  sample accepted when in_valid&in_ready
in_feats  in  N_FEAT*FEAT_W  features; feature i at [i*FEAT_W +: FEAT_W]
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid&out_ready
out_class  out  CLASS_W  class label
out_depth  out  $clog2(MAX_DEPTH+1)  internal nodes traversed
out_err  out  1  walk aborted

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Node word: NODE_W = 1 + FIDX_W + FEAT_W + 2*AW, where FIDX_W = $clog2(N_FEAT) and AW = $clog2(N_NODES). Default NODE_W is 25.
- Field order, MSB first: leaf, fidx, thresh, left, right.
- Leaf node: class is the low CLASS_W bits; all other bits are ignored.
- Decision rule: feats[fidx] <= thresh goes to left, otherwise to right. Compare is unsigned, full FEAT_W.
- Reset:
  - state is IDLE; all outputs are 0 except cfg_ready=1 and in_ready=1.
  - Every table entry resets to leaf, class 0.
- FSM IDLE:
  - cfg_we writes the table at the clock edge, and in_ready=0 in that cycle. Configuration has priority over samples.
  - Otherwise in_valid&in_ready captures in_feats, sets ptr=0 and depth=0, and goes to WALK.
- FSM WALK, each cycle, using an asynchronous read of entry ptr:
  - Leaf: latch class, go to DONE.
  - Internal: ptr<=child and depth<=depth+1.
  - Error: if depth==MAX_DEPTH on an internal node, or the child index is >= N_NODES, go to DONE with out_err=1, out_class=0, and out_depth holding the current depth.
- FSM DONE:
  - out_valid=1; outputs stay stable until out_ready.
  - On handshake, go to IDLE. in_ready reasserts in the next cycle; there is no same-cycle re-accept.
- Latency: for a path with D internal nodes, out_valid rises after edge E0+D+1, where E0 is the accept edge.
- Config protection: cfg_we outside IDLE is ignored and the table is unchanged.
- Reset mid-walk or in DONE: immediate return to the IDLE reset values. The table also returns to its reset contents.

Optional Feature:
DTREE_PERF_CNT_EN
- Defined: adds outputs perf_infer [15:0] and perf_cycles [15:0].
  - perf_infer counts completed output handshakes.
  - perf_cycles counts cycles spent in WALK.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: the ports and logic are absent.

Decomposition:
- Package dtree_pkg:
  - state enum: IDLE, WALK, DONE
  - node struct with fields leaf, fidx, thresh, left, right
  - width localparam functions for FIDX_W, AW, NODE_W
  - reset node constant
- Sub-module dtree_node_table: register-file table with one synchronous write port, one asynchronous read port, and per-entry async reset to the leaf-class-0 node.

Test Plan:
- Reset then sample X16=8'd100 with nothing loaded -> class 0, depth 0, out_valid 1 cycle after accept.
- Load the following, all other features 0:
  - n0: fidx 15, thr 127, left 1, right 2
  - n1: leaf class 5
  - n2: fidx 15, thr 191, left 3, right 4
  - n3: leaf class 7
  - n4: leaf class 9
  Feature 15 values and required results:
  - 100 -> class 5, depth 1, latency 2
  - 127 -> class 5
  - 128 -> class 7, depth 2
  - 200 -> class 9, depth 2, latency 3
- Hold out_ready=0 for 5 cycles on the class 9 result -> out_class, out_depth and out_valid stay stable; in_ready=0; cfg_we in this window leaves n4 unchanged.
- Set n0 left=0 and right=0 -> out_err=1, class 0, depth 15, latency 16.
- Set n2 right=63 with n63 internal, then sample 255 -> err at the second node if that child >= N_NODES; otherwise follows the path.
- Assert rst at the second WALK cycle -> next cycle in_ready=1 and out_valid=0; the table is back to leaf 0, so a new sample returns class 0.
